// File: rtl/coin_pkg.sv
// rtl/coin_pkg.sv - shared types and constants for the coin front end and accumulator
package coin_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_WAIT = 2'd1,
    HELD       = 2'd2,
    REL_WAIT   = 2'd3
  } db_state_e;

  localparam int unsigned COIN_A_VAL = 5;
  localparam int unsigned COIN_B_VAL = 10;

endpackage

// File: rtl/pb_debounce.sv
// rtl/pb_debounce.sv - one push-button channel: 2-flop synchroniser, debounce FSM, stability counter
module pb_debounce
  import coin_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pb,
  input  logic block,
  output logic accept,
  output logic active
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync1_q, sync2_q;
  logic             pressed;
  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Synchroniser idles at 1 so a reset never looks like a press edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= pb;
      sync2_q <= sync1_q;
    end
  end

  assign pressed = ~sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (pressed && !block) begin
          state_d = PRESS_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      PRESS_WAIT: begin
        if (!pressed) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          accept  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HELD: begin
        cnt_d = '0;
        if (!pressed) begin
          state_d = REL_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      REL_WAIT: begin
        if (pressed) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign active = (state_q != IDLE);

endmodule

// File: rtl/coin_debounce.sv
// rtl/coin_debounce.sv - two debounced coin buttons to single-cycle coin5/coin10 pulses
// Optional cross-channel lockout: COIN_DEBOUNCE_LOCKOUT_EN
module coin_debounce
  import coin_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pb0,
  input  logic pb1,
  output logic coin5,
  output logic coin10,
  output logic busy
);

  logic accept0, accept1;
  logic active0, active1;
  logic block0, block1;
  logic coin5_q, coin5_d;
  logic coin10_q, coin10_d;

`ifdef COIN_DEBOUNCE_LOCKOUT_EN
  // Blocks sample registered state only, so same-cycle departures from IDLE both proceed.
  assign block0 = active1;
  assign block1 = active0;
`else
  assign block0 = 1'b0;
  assign block1 = 1'b0;
`endif

  pb_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_ch0 (
    .clk   (clk),
    .rst_n (rst_n),
    .pb    (pb0),
    .block (block0),
    .accept(accept0),
    .active(active0)
  );

  pb_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_ch1 (
    .clk   (clk),
    .rst_n (rst_n),
    .pb    (pb1),
    .block (block1),
    .accept(accept1),
    .active(active1)
  );

  // A coincident 10-unit accept loses to the 5-unit one and is not retried.
  assign coin5_d  = accept0;
  assign coin10_d = accept1 & ~accept0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coin5_q  <= 1'b0;
      coin10_q <= 1'b0;
    end else begin
      coin5_q  <= coin5_d;
      coin10_q <= coin10_d;
    end
  end

  assign coin5  = coin5_q;
  assign coin10 = coin10_q;
  assign busy   = active0 | active1;

endmodule

// File: tb/tb_coin_debounce.sv
// tb/tb_coin_debounce.sv - directed self-checking bench for coin_debounce with DEBOUNCE_CYCLES=8
module tb_coin_debounce;

  localparam int DC = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic pb0, pb1;
  logic coin5, coin10, busy;

  int cyc = 0;
  int n5 = 0, n10 = 0;
  int last5 = -1, last10 = -1;
  int errors = 0, checks = 0;
  int t, r, f, b5, b10;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Every high cycle is counted, so a stretched pulse shows up as count > 1.
  always @(negedge clk) begin
    if (coin5) begin
      n5    <= n5 + 1;
      last5 <= cyc;
    end
    if (coin10) begin
      n10    <= n10 + 1;
      last10 <= cyc;
    end
  end

  coin_debounce #(
    .DEBOUNCE_CYCLES(DC),
    .CNT_W          (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pb0   (pb0),
    .pb1   (pb1),
    .coin5 (coin5),
    .coin10(coin10),
    .busy  (busy)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic goto(input int k);
    while (cyc < k) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    pb0   = 1'b1;
    pb1   = 1'b1;
    goto(2);
    check("rst_coin5", coin5, 0);
    check("rst_coin10", coin10, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;

    // clean press on pb0 at cycle 10
    goto(10);
    pb0 = 1'b0;
    t = cyc;
    goto(t + 30);
    check("clean_busy_held", busy, 1);
    goto(t + 40);
    pb0 = 1'b1;
    r = cyc;
    goto(r + 9);
    check("clean_busy_relwait", busy, 1);
    goto(r + 11);
    check("clean_busy_idle", busy, 0);
    check("clean_n5", n5, 1);
    check("clean_cycle5", last5, 20);
    check("clean_n10", n10, 0);

    // bounce on pb1: 4x (low 5, high 1) then held low
    b5 = n5; b10 = n10;
    goto(cyc + 5);
    for (int i = 0; i < 4; i++) begin
      pb1 = 1'b0;
      goto(cyc + 5);
      pb1 = 1'b1;
      goto(cyc + 1);
    end
    pb1 = 1'b0;
    f = cyc;
    goto(f + 30);
    pb1 = 1'b1;
    goto(cyc + 15);
    check("bounce_n10", n10 - b10, 1);
    check("bounce_cycle10", last10, f + 10);
    check("bounce_n5", n5 - b5, 0);
    check("bounce_busy", busy, 0);

    // release bounce after an accepted pb0 press
    pb0 = 1'b0;
    t = cyc;
    goto(t + 15);
    check("relb_first_cycle5", last5, t + 10);
    b5 = n5;
    for (int i = 0; i < 3; i++) begin
      pb0 = 1'b1;
      goto(cyc + 3);
      pb0 = 1'b0;
      goto(cyc + 2);
    end
    pb0 = 1'b1;
    goto(cyc + 5);
    check("relb_busy_wait", busy, 1);
    goto(cyc + 15);
    check("relb_n5", n5 - b5, 0);
    check("relb_busy_idle", busy, 0);

    // simultaneous press: coin5 wins, coin10 dropped
    b5 = n5; b10 = n10;
    pb0 = 1'b0;
    pb1 = 1'b0;
    t = cyc;
    goto(t + 20);
    pb0 = 1'b1;
    pb1 = 1'b1;
    goto(cyc + 15);
    check("simul_n5", n5 - b5, 1);
    check("simul_cycle5", last5, t + 10);
    check("simul_n10", n10 - b10, 0);
    check("simul_busy", busy, 0);

    // pb0 held, pb1 pressed 3 cycles later
    b5 = n5; b10 = n10;
    pb0 = 1'b0;
    t = cyc;
    goto(t + 3);
    pb1 = 1'b0;
    goto(t + 23);
    pb1 = 1'b1;
    goto(t + 40);
    pb0 = 1'b1;
    goto(t + 60);
    check("lock_n5", n5 - b5, 1);
    check("lock_cycle5", last5, t + 10);
`ifdef COIN_DEBOUNCE_LOCKOUT_EN
    check("lock_n10", n10 - b10, 0);
`else
    check("lock_n10", n10 - b10, 1);
    check("lock_cycle10", last10, t + 13);
`endif
    check("lock_busy", busy, 0);

    // reset during PRESS_WAIT at cnt=5, button held through release
    b5 = n5;
    pb0 = 1'b0;
    t = cyc;
    goto(t + 7);
    check("rstmid_busy_before", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstmid_busy_async", busy, 0);
    check("rstmid_coin5", coin5, 0);
    check("rstmid_coin10", coin10, 0);
    @(negedge clk);
    rst_n = 1'b1;
    r = cyc;
    goto(r + 9);
    check("rstmid_no_early", n5 - b5, 0);
    goto(r + 12);
    check("rstmid_n5", n5 - b5, 1);
    check("rstmid_cycle5", last5, r + 10);
    pb0 = 1'b1;
    goto(cyc + 15);
    check("rstmid_busy_end", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
